// File: rtl/keyframe_fader.sv
// Keyframe fader: holds a target and a live LED frame, and steps every channel
// linearly from a snapshot of the live frame toward the target on each fade tick.
module keyframe_fader #(
    parameter int unsigned c_ledboards = 30,
    parameter int unsigned c_bpc       = 12,
    parameter int unsigned c_max_time  = 1024,
    parameter int unsigned c_max_type  = 64,
    parameter int unsigned c_channels  = c_ledboards * 32,
    parameter int unsigned c_addr_w    = $clog2(c_channels),
    parameter int unsigned c_time_w    = $clog2(c_max_time),
    parameter int unsigned c_type_w    = $clog2(c_max_type)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wen,
    input  logic [c_addr_w-1:0] i_addr,
    input  logic [c_bpc-1:0]    i_data,
    input  logic [c_time_w-1:0] i_time,
    input  logic [c_type_w-1:0] i_type,
    input  logic                i_tick,
    input  logic [c_addr_w-1:0] i_rd_addr,
    output logic [c_bpc-1:0]    o_rd_data,
    output logic                o_busy
);

    // Fade fraction f is fixed point with 10 fractional bits; 1024 means "at target".
    localparam int unsigned c_fw    = 10;
    localparam int unsigned c_fone  = 1024;
    localparam int unsigned c_qw    = c_fw + 1;
    localparam int unsigned c_cnt_w = $clog2(c_qw);
    localparam int unsigned c_pw    = c_bpc + c_qw + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_WAIT,
        S_DIV,
        S_SWEEP
    } state_t;

    state_t              state_q, state_d;
    logic [c_addr_w-1:0] idx_q,   idx_d;
    logic [c_time_w-1:0] step_q,  step_d;
    logic [c_time_w-1:0] dur_q,   dur_d;
    logic [c_type_w-1:0] typ_q,   typ_d;
    logic [c_qw-1:0]     f_q,     f_d;
    logic [c_time_w-1:0] rem_q,   rem_d;
    logic [c_qw-1:0]     dvd_q,   dvd_d;
    logic [c_cnt_w-1:0]  cnt_q,   cnt_d;
    logic                pend_q,  pend_d;
    logic                busy_q,  busy_d;

    logic                snap_we_c;
    logic                sweep_we_c;
    logic                addr_ok_c;
    logic                rd_ok_c;
    logic                commit_c;
    logic                last_c;
    logic [c_time_w-1:0] step_inc_c;
    logic [c_time_w:0]   trial_c;
    logic                qbit_c;

    logic [c_bpc-1:0]        target_mem [c_channels];
    logic [c_bpc-1:0]        start_mem  [c_channels];
    logic [c_bpc-1:0]        live_mem   [c_channels];

    logic [c_bpc-1:0]        tgt_rd_c;
    logic [c_bpc-1:0]        st_rd_c;
    logic signed [c_bpc:0]   diff_c;
    logic signed [c_pw-1:0]  prod_c;
    logic [c_bpc-1:0]        sweep_val_c;

    assign addr_ok_c  = 32'(i_addr) < c_channels;
    assign rd_ok_c    = 32'(i_rd_addr) < c_channels;
    assign commit_c   = i_wen && (32'(i_addr) == c_channels - 1);
    assign last_c     = (idx_q == c_addr_w'(c_channels - 1));
    assign step_inc_c = step_q + c_time_w'(1);

    // Restoring divider trial: bring down the next dividend bit and compare to dur.
    assign trial_c = {rem_q, dvd_q[c_qw-1]};
    assign qbit_c  = (trial_c >= {1'b0, dur_q});

    // Sweep datapath: live = start + floor((target - start) * f / 1024).
    assign tgt_rd_c    = target_mem[idx_q];
    assign st_rd_c     = start_mem[idx_q];
    assign diff_c      = $signed({1'b0, tgt_rd_c}) - $signed({1'b0, st_rd_c});
    assign prod_c      = c_pw'(diff_c) * c_pw'($signed({1'b0, f_q}));
    assign sweep_val_c = st_rd_c + c_bpc'(prod_c >>> c_fw);

    // Control state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            step_q  <= '0;
            dur_q   <= '0;
            typ_q   <= '0;
            f_q     <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            dur_q   <= dur_d;
            typ_q   <= typ_d;
            f_q     <= f_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: snapshot, wait for tick, divide, sweep; commit overrides all.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        step_d     = step_q;
        dur_d      = dur_q;
        typ_d      = typ_q;
        f_d        = f_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        snap_we_c  = 1'b0;
        sweep_we_c = 1'b0;

        case (state_q)
            S_IDLE: begin
            end
            S_SNAP: begin
                snap_we_c = 1'b1;
                idx_d     = idx_q + c_addr_w'(1);
                if (last_c) begin
                    idx_d = '0;
                    if (typ_q == '0 || dur_q == '0) begin
                        f_d     = c_qw'(c_fone);
                        state_d = S_SWEEP;
                    end else begin
                        step_d  = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (i_tick || pend_q) begin
                    step_d  = step_inc_c;
                    pend_d  = 1'b0;
                    rem_d   = step_inc_c >> 1;
                    dvd_d   = {step_inc_c[0], {c_fw{1'b0}}};
                    f_d     = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                pend_d = pend_q | i_tick;
                rem_d  = qbit_c ? c_time_w'(trial_c - {1'b0, dur_q})
                                : trial_c[c_time_w-1:0];
                dvd_d  = {dvd_q[c_qw-2:0], 1'b0};
                f_d    = {f_q[c_qw-2:0], qbit_c};
                cnt_d  = cnt_q + c_cnt_w'(1);
                if (cnt_q == c_cnt_w'(c_qw - 1)) begin
                    idx_d   = '0;
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                pend_d     = pend_q | i_tick;
                sweep_we_c = 1'b1;
                idx_d      = idx_q + c_addr_w'(1);
                if (last_c) begin
                    idx_d = '0;
                    if (f_q == c_qw'(c_fone)) begin
                        busy_d  = 1'b0;
                        pend_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit_c) begin
            state_d    = S_SNAP;
            idx_d      = '0;
            dur_d      = i_time;
            typ_d      = i_type;
            busy_d     = 1'b1;
            pend_d     = 1'b0;
            snap_we_c  = 1'b0;
            sweep_we_c = 1'b0;
        end
    end

    // Target frame: written by the decoder in any state.
    always_ff @(posedge i_clk) begin
        if (i_wen && addr_ok_c) begin
            target_mem[i_addr] <= i_data;
        end
    end

    // Start frame: snapshot of live taken at the beginning of each keyframe.
    always_ff @(posedge i_clk) begin
        if (snap_we_c) begin
            start_mem[idx_q] <= live_mem[idx_q];
        end
    end

    // Live frame: updated one channel per cycle by the sweep.
    always_ff @(posedge i_clk) begin
        if (sweep_we_c) begin
            live_mem[idx_q] <= sweep_val_c;
        end
    end

    // LED driver read port, one cycle latency.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= rd_ok_c ? live_mem[i_rd_addr] : '0;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: tb/tb_keyframe_fader.sv
// Directed bench for keyframe_fader with a 32-channel configuration.
module tb_keyframe_fader;

    localparam int unsigned c_ledboards = 1;
    localparam int unsigned c_bpc       = 12;
    localparam int unsigned c_addr_w    = 5;
    localparam int unsigned c_time_w    = 10;
    localparam int unsigned c_type_w    = 6;

    logic                clk;
    logic                rst;
    logic                wen;
    logic [c_addr_w-1:0] addr;
    logic [c_bpc-1:0]    data;
    logic [c_time_w-1:0] ktime;
    logic [c_type_w-1:0] ktype;
    logic                tick;
    logic [c_addr_w-1:0] rd_addr;
    logic [c_bpc-1:0]    rd_data;
    logic                busy;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned rv;

    keyframe_fader #(
        .c_ledboards (c_ledboards),
        .c_bpc       (c_bpc)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wen     (wen),
        .i_addr    (addr),
        .i_data    (data),
        .i_time    (ktime),
        .i_type    (ktype),
        .i_tick    (tick),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data),
        .o_busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write one full keyframe; the write to channel 31 commits it.
    task automatic write_frame(input logic [c_bpc-1:0] val, input logic [c_time_w-1:0] t,
                               input logic [c_type_w-1:0] ty);
        for (int ch = 0; ch < 32; ch++) begin
            @(negedge clk);
            wen   = 1'b1;
            addr  = c_addr_w'(ch);
            data  = val;
            ktime = t;
            ktype = ty;
        end
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic read_ch(input int ch, output int unsigned val);
        @(negedge clk);
        rd_addr = c_addr_w'(ch);
        @(negedge clk);
        val = 32'(rd_data);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wen      = 1'b0;
        addr     = '0;
        data     = '0;
        ktime    = '0;
        ktype    = '0;
        tick     = 1'b0;
        rd_addr  = '0;

        repeat (3) @(negedge clk);
        check_val("reset_rd_data", 32'(rd_data), 0);
        check_val("reset_busy", 32'(busy), 0);
        rst = 1'b0;

        // Instant keyframe (time 0): busy for exactly SNAP + SWEEP.
        write_frame(12'h100, 10'd0, 6'd1);
        check_val("t1_busy_after_commit", 32'(busy), 1);
        repeat (63) @(negedge clk);
        check_val("t1_busy_last_sweep", 32'(busy), 1);
        @(negedge clk);
        check_val("t1_busy_done", 32'(busy), 0);
        for (int ch = 0; ch < 32; ch++) begin
            read_ch(ch, rv);
            check_val($sformatf("t1_ch%0d", ch), rv, 32'h100);
        end

        // Four-step fade up; a tick during SNAP must be ignored.
        write_frame(12'h500, 10'd4, 6'd1);
        repeat (5) @(negedge clk);
        pulse_tick();
        repeat (40) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            pulse_tick();
            repeat (98) @(negedge clk);
            read_ch(5, rv);
            check_val($sformatf("t2_ch5_step%0d", k), rv, 32'h100 + 32'h100 * k);
            check_val($sformatf("t2_busy_step%0d", k), 32'(busy), (k < 4) ? 1 : 0);
        end

        // Fade down over three steps, floor rounding on negative deltas.
        write_frame(12'h0FF, 10'd3, 6'd1);
        repeat (40) @(negedge clk);
        pulse_tick();
        repeat (98) @(negedge clk);
        read_ch(0, rv);
        check_val("t3_ch0_step1", rv, 32'h3AA);
        pulse_tick();
        repeat (98) @(negedge clk);
        read_ch(0, rv);
        check_val("t3_ch0_step2", rv, 32'h255);
        pulse_tick();
        repeat (98) @(negedge clk);
        read_ch(0, rv);
        check_val("t3_ch0_final", rv, 32'h0FF);
        read_ch(31, rv);
        check_val("t3_ch31_final", rv, 32'h0FF);
        check_val("t3_busy_done", 32'(busy), 0);

        // Three ticks in quick succession: one pending step kept, the third dropped.
        write_frame(12'h4FF, 10'd4, 6'd1);
        repeat (40) @(negedge clk);
        pulse_tick();
        repeat (3) @(negedge clk);
        pulse_tick();
        repeat (20) @(negedge clk);
        pulse_tick();
        repeat (150) @(negedge clk);
        read_ch(0, rv);
        check_val("t4_ch0_two_steps", rv, 32'h2FF);
        read_ch(31, rv);
        check_val("t4_ch31_two_steps", rv, 32'h2FF);
        check_val("t4_busy_mid_fade", 32'(busy), 1);

        // New commit mid-fade: snapshot is the intermediate frame.
        write_frame(12'h6FF, 10'd2, 6'd1);
        repeat (40) @(negedge clk);
        pulse_tick();
        repeat (98) @(negedge clk);
        read_ch(0, rv);
        check_val("t5_ch0_step1", rv, 32'h4FF);
        check_val("t5_busy_step1", 32'(busy), 1);
        pulse_tick();
        repeat (98) @(negedge clk);
        read_ch(7, rv);
        check_val("t5_ch7_final", rv, 32'h6FF);
        check_val("t5_busy_done", 32'(busy), 0);

        // Type 0 is instant; reset in the middle of its sweep freezes the frame.
        write_frame(12'h0FF, 10'd5, 6'd0);
        repeat (42) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_busy_in_reset", 32'(busy), 0);
        check_val("t6_rd_data_in_reset", 32'(rd_data), 0);
        rst = 1'b0;
        pulse_tick();
        repeat (60) @(negedge clk);
        check_val("t6_busy_after_reset", 32'(busy), 0);
        read_ch(0, rv);
        check_val("t6_ch0_swept", rv, 32'h0FF);
        read_ch(9, rv);
        check_val("t6_ch9_swept", rv, 32'h0FF);
        read_ch(10, rv);
        check_val("t6_ch10_unswept", rv, 32'h6FF);
        read_ch(31, rv);
        check_val("t6_ch31_unswept", rv, 32'h6FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keyframe_fader.md
Name: keyframe_fader

Overview:
- Downstream consumer of the SPI protocol decoder's keyframe write stream (wen/addr/data/time/type).
- Holds a target frame and a live output frame.
- Per fade tick, linearly interpolates each channel from a snapshot of the live frame toward the target over the keyframe duration.
- Exposes the live frame on a synchronous read port for the LED driver.

Parameters:
c_ledboards, 30, number of LED boards
c_bpc, 12, bits per channel
c_max_time, 1024, max keyframe duration in ticks
c_max_type, 64, number of keyframe types
c_channels, c_ledboards*32, channel count
c_addr_w, $clog2(c_channels), channel address width
c_time_w, $clog2(c_max_time), duration width
c_type_w, $clog2(c_max_type), type width

Ports:
i_clk  in  1  system clock; all logic on posedge
i_rst  in  1  asynchronous, active-high reset
i_wen  in  1  write strobe from protocol decoder, one cycle per channel
i_addr  in  c_addr_w  channel address of write
i_data  in  c_bpc  target channel value
i_time  in  c_time_w  keyframe duration in ticks, sampled at commit
i_type  in  c_type_w  keyframe type, sampled at commit
i_tick  in  1  fade-step strobe, one cycle wide
i_rd_addr  in  c_addr_w  LED driver read address
o_rd_data  out  c_bpc  live value of channel i_rd_addr, 1-cycle latency
o_busy  out  1  high from commit until fade complete

Behaviour:
- Reset: o_rd_data=0, o_busy=0, FSM=IDLE, step=0, tick pending=0. Frame contents undefined; the first keyframe defines them.
- Storage: three c_channels x c_bpc arrays: target, start, live.
  - live is dual-ported: the sweep writes it; the read port reads it.
- Writes:
  - i_wen writes target[i_addr]=i_data in any state. Writes mid-fade affect subsequent sweeps.
  - i_addr >= c_channels is ignored.
- Commit: i_wen with i_addr==c_channels-1.
  - Latch dur=i_time and typ=i_type; set o_busy=1 next cycle.
  - Enter SNAP, aborting any fade in progress.
  - Commit during SNAP restarts SNAP at channel 0.
- FSM states:
  - IDLE: wait for commit.
  - SNAP: copy live[n] to start[n], one channel per cycle for c_channels cycles.
    - If typ==0 or dur==0, set f=1024 and go to SWEEP (instant).
    - Otherwise step=0 and go to WAIT.
  - WAIT: on i_tick, step=step+1 and go to DIV.
  - DIV: compute f=floor(step*1024/dur) with a sequential restoring divider, 1 quotient bit per cycle, 11 cycles. Then go to SWEEP.
  - SWEEP: for n=0..c_channels-1, one per cycle:
    - live[n] = start[n] + ((target[n]-start[n])*f >>> 10).
    - Difference is signed c_bpc+1 bits; the shift is arithmetic (floor). The result always lies between start and target, so no clamp is needed.
    - At end of sweep: if f==1024 (step==dur or instant), go to IDLE and set o_busy=0; else go to WAIT.
- Ticks:
  - i_tick in IDLE/SNAP is ignored.
  - i_tick in DIV/SWEEP sets a one-deep pending flag; further ticks while pending is set are dropped. On entering WAIT with pending set, the step is consumed immediately and pending clears.
- Final value: at step==dur, f=1024 exactly, so live==target bit-exact.
- Read port: o_rd_data <= live[i_rd_addr] every cycle, including during a sweep.
  - Reading the address being swept in the same cycle returns the old value.
- Reset mid-operation returns to IDLE immediately. live retains contents but fading stops.

Test Plan:
- c_ledboards=1 (32 channels). Write ch0..31=0x100, type=1, time=0 → o_busy high; after SNAP+SWEEP (64 cycles), o_busy=0 and reads of all channels return 0x100.
- Then write all channels=0x500, time=4, type=1; issue 4 ticks spaced 100 cycles → after each sweep ch5 = 0x200, 0x300, 0x400, 0x500; o_busy drops after the 4th.
- Fade down from 0x500 to 0x0FF with time=3 → ch0 after tick1 = 0x500+floor(-0x401*341/1024) = 0x3AA; final value 0x0FF exact.
- Two ticks inside one DIV+SWEEP window → exactly one extra step is applied after the sweep, and the second extra tick is dropped; step count is verified via the ch value.
- New commit (time=2) issued mid-fade at step 2 of 4 → SNAP captures the intermediate live values; the fade completes in 2 ticks to the new target.
- Assert i_rst during SWEEP → o_busy=0 and o_rd_data=0 next edge. Ticks are then ignored; reads show the partially swept frame.
